// File: rtl/seqdec_param.sv
// seqdec_param: parametrised serial pattern detector.
// A gated serial bit stream is shifted MSB-first into a W-bit window. The
// window is compared against a runtime-programmable pattern under a care-mask.
// The block emits a one-cycle match pulse and keeps a saturating match count.
// Optional feature: define SEQDEC_NONOVERLAP_EN to stop matches from sharing
// bits. After each hit the fill count restarts, so W fresh valid bits are
// needed before the next hit.
module seqdec_param #(
  parameter int W     = 8,  // pattern/window width, 2..64
  parameter int CNT_W = 8   // match counter width
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InA,
  input  logic             InValid,
  input  logic [W-1:0]     Pattern,
  input  logic [W-1:0]     Mask,
  input  logic             Clear,
  output logic             Out,
  output logic [CNT_W-1:0] MatchCnt,
  output logic             Sat
);

  // fill counts 0..W, so it needs enough bits to hold W itself.
  localparam int FW = $clog2(W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(W);

  logic [W-1:0]     sr;
  logic [W-1:0]     sr_next;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic             hit;
  logic [CNT_W-1:0] cnt_next;

  // Next-state logic: shift, fill tracking, match decision and counter update.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path through it leaves a signal unassigned and no latch is inferred.
    sr_next   = sr;
    fill_next = fill;
    hit       = 1'b0;
    cnt_next  = MatchCnt;

    if (Clear) begin
      // Clear wins over a valid bit; the bit presented this cycle is dropped.
      sr_next   = '0;
      fill_next = '0;
      cnt_next  = '0;
    end else if (InValid) begin
      sr_next   = {sr[W-2:0], InA};
      fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
      // A hit needs a full window and agreement on every cared-for bit.
      hit       = (fill_next == FILL_FULL) &&
                  (((sr_next ^ Pattern) & Mask) == '0);
`ifdef SEQDEC_NONOVERLAP_EN
      // Restart the fill so the next match is built from fresh bits only.
      if (hit) fill_next = '0;
`else
      // Overlapping detection: the window stays full and may match again.
`endif
      if (hit && (MatchCnt != '1)) cnt_next = MatchCnt + CNT_W'(1);
    end
  end

  // State and output registers; every output is registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr       <= '0;
      fill     <= '0;
      Out      <= 1'b0;
      MatchCnt <= '0;
      Sat      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all registers
      // update together from values sampled at the same edge.
      sr       <= sr_next;
      fill     <= fill_next;
      Out      <= hit;
      MatchCnt <= cnt_next;
      Sat      <= (cnt_next == '1);
    end
  end

endmodule

// File: tb/tb_seqdec_param.sv
// tb_seqdec_param: directed bench for seqdec_param.
// Two instances share all inputs. One uses the default 8-bit counter. The
// other uses a 2-bit counter so that saturation is reachable in a few matches.
// Inputs change just after a negedge. Outputs are checked at the next negedge.
module tb_seqdec_param;

`ifdef SEQDEC_NONOVERLAP_EN
  localparam bit NONOV = 1'b1;
`else
  localparam bit NONOV = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_a;
  logic       in_valid;
  logic [7:0] pattern;
  logic [7:0] mask;
  logic       clear;

  logic       d_out;
  logic [7:0] d_cnt;
  logic       d_sat;
  logic       s_out;
  logic [1:0] s_cnt;
  logic       s_sat;

  int passed = 0;
  int total  = 0;

  seqdec_param #(.W(8), .CNT_W(8)) dut (
    .Clk(clk), .Reset_n(rst_n), .InA(in_a), .InValid(in_valid),
    .Pattern(pattern), .Mask(mask), .Clear(clear),
    .Out(d_out), .MatchCnt(d_cnt), .Sat(d_sat)
  );

  seqdec_param #(.W(8), .CNT_W(2)) dut_s (
    .Clk(clk), .Reset_n(rst_n), .InA(in_a), .InValid(in_valid),
    .Pattern(pattern), .Mask(mask), .Clear(clear),
    .Out(s_out), .MatchCnt(s_cnt), .Sat(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, then advance to the following negedge.
  task automatic step(input logic a, input logic v, input logic c);
    in_a     = a;
    in_valid = v;
    clear    = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  // Send n bits MSB-first. pulses[i] is the expected Out after bit i+1.
  task automatic feed(input logic [31:0] data, input int n,
                      input logic [31:0] pulses, input string tag);
    for (int i = 0; i < n; i++) begin
      step(data[n-1-i], 1'b1, 1'b0);
      check($sformatf("%s_out_bit%0d", tag, i + 1), 64'(d_out), 64'(pulses[i]));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_a     = 1'b0;
    in_valid = 1'b0;
    pattern  = 8'h00;
    mask     = 8'hFF;
    clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    check("rst_out", 64'(d_out), 64'd0);
    check("rst_cnt", 64'(d_cnt), 64'd0);
    check("rst_sat", 64'(d_sat), 64'd0);
    check("rst_s_cnt", 64'(s_cnt), 64'd0);
    check("rst_s_sat", 64'(s_sat), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic detection of 8'h53.
    pattern = 8'h53;
    mask    = 8'hFF;
    feed(32'h53, 8, 32'h80, "basic");
    check("basic_cnt", 64'(d_cnt), 64'd1);
    check("basic_s_cnt", 64'(s_cnt), 64'd1);
    check("basic_s_sat", 64'(s_sat), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    check("basic_idle_out", 64'(d_out), 64'd0);

    // Clear together with a valid bit.
    step(1'b1, 1'b1, 1'b1);
    check("clr1_cnt", 64'(d_cnt), 64'd0);
    check("clr1_out", 64'(d_out), 64'd0);

    // Fill gating: all-zero pattern, ten zeros.
    pattern = 8'h00;
    feed(32'h0, 10, NONOV ? 32'h080 : 32'h380, "fill");
    check("fill_cnt", 64'(d_cnt), NONOV ? 64'd1 : 64'd3);
    step(1'b0, 1'b0, 1'b1);

    // Overlap: 8'hAA inside 16'hAAAA.
    pattern = 8'hAA;
    feed(32'hAAAA, 16, NONOV ? 32'h8080 : 32'hAA80, "ovl");
    check("ovl_cnt", 64'(d_cnt), NONOV ? 64'd2 : 64'd5);
    step(1'b0, 1'b0, 1'b1);

    // Saturation: 32 zeros give at least 4 matches.
    pattern = 8'h00;
    feed(32'h0, 32, NONOV ? 32'h80808080 : 32'hFFFFFF80, "sat");
    check("sat_cnt", 64'(d_cnt), NONOV ? 64'd4 : 64'd25);
    check("sat_s_cnt", 64'(s_cnt), 64'd3);
    check("sat_s_sat", 64'(s_sat), 64'd1);
    check("sat_d_sat", 64'(d_sat), 64'd0);

    // Clear with InValid high: the zero bit shown that cycle must be dropped.
    step(1'b0, 1'b1, 1'b1);
    check("clr2_s_cnt", 64'(s_cnt), 64'd0);
    check("clr2_s_sat", 64'(s_sat), 64'd0);
    check("clr2_out", 64'(d_out), 64'd0);
    feed(32'h0, 8, 32'h80, "fresh");
    check("fresh_cnt", 64'(d_cnt), 64'd1);
    step(1'b0, 1'b0, 1'b1);

    // Mask and stalls: 8'h53 under mask F0 against 8'h50, with a 3-cycle gap.
    pattern = 8'h50;
    mask    = 8'hF0;
    feed(32'h5, 4, 32'h0, "mask_hi");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("stall_out%0d", i), 64'(d_out), 64'd0);
    end
    feed(32'h3, 4, 32'h8, "mask_lo");
    check("mask_cnt", 64'(d_cnt), 64'd1);
    check("mask_s_cnt", 64'(s_cnt), 64'd1);

    // Reset mid-pattern: five bits of 8'h53, then an asynchronous reset.
    pattern = 8'h53;
    mask    = 8'hFF;
    feed(32'h0A, 5, 32'h0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 64'(d_out), 64'd0);
    check("arst_cnt", 64'(d_cnt), 64'd0);
    check("arst_sat", 64'(d_sat), 64'd0);
    check("arst_s_cnt", 64'(s_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed(32'h53, 8, 32'h80, "post_rst");
    check("post_rst_cnt", 64'(d_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
